// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding and colour helpers for the Simon sequencer.
package simon_pkg;
  localparam int COLOUR_W = 2;
  localparam int NUM_COLOURS = 4;
  typedef enum logic [3:0] {
    S_IDLE, S_REWIND, S_SETTLE, S_SHOW, S_ADV, S_GAP,
    S_REWIND_IN, S_SETTLE_IN, S_WAIT_IN, S_ADV_IN, S_DONE
  } state_t;
  function automatic logic [NUM_COLOURS-1:0] colour_led(input logic [COLOUR_W-1:0] c);
    return NUM_COLOURS'(1) << c;
  endfunction
endpackage

// File: rtl/tick_timer.sv
// tick_timer: loadable down-counter; done on the last of N enabled cycles.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign done_o = en_i && (cnt_q < W'(2));
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: plays an LFSR-derived colour sequence, then checks the player's presses.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int ON_TICKS      = 25_000_000,
  parameter int OFF_TICKS     = 12_500_000,
  parameter int TIMEOUT_TICKS = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] level,
  input  logic       random,
  input  logic [2:0] next_random,
  input  logic [3:0] btn,
  output logic       lfsr_step,
  output logic       lfsr_rerun,
  output logic [3:0] led,
  output logic       busy,
  output logic       pass,
  output logic       fail
);
  localparam int MAX_A = ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T = MAX_A > TIMEOUT_TICKS ? MAX_A : TIMEOUT_TICKS;
  localparam int TW = $clog2(MAX_T + 1);
  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d, len_q, len_d;
  logic [COLOUR_W-1:0] colour_q, colour_d, colour_now;
  logic ph_q, ph_d;
  logic t_load, t_en, t_done, good, bad;
  logic [TW-1:0] t_val;
  logic unused_bits;
  assign unused_bits = ^next_random[2:1];
  assign colour_now = {next_random[0], random};
  assign good = btn == colour_led(colour_now);
  assign bad = !good && (|btn || t_done);
  tick_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load_i(t_load), .en_i(t_en), .val_i(t_val), .done_o(t_done)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    colour_d = colour_q;
    ph_d = ph_q;
    t_load = 1'b0;
    t_val = '0;
    t_en = 1'b0;
    led = '0;
    busy = state_q != S_IDLE;
    pass = 1'b0;
    fail = 1'b0;
    lfsr_step = 1'b0;
    lfsr_rerun = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_REWIND;
        len_d = (level == 5'd0) ? 5'd1 : level;
        idx_d = '0;
      end
      S_REWIND, S_REWIND_IN: begin
        lfsr_rerun = 1'b1;
        state_d = (state_q == S_REWIND) ? S_SETTLE : S_SETTLE_IN;
      end
      S_SETTLE: begin
        state_d = S_SHOW;
        colour_d = colour_now;
        t_load = 1'b1;
        t_val = TW'(ON_TICKS);
      end
      S_SHOW: begin
        led = colour_led(colour_q);
        t_en = 1'b1;
        state_d = t_done ? S_ADV : S_SHOW;
      end
      S_ADV, S_ADV_IN: begin
        lfsr_step = 1'b1;
        ph_d = !ph_q;
        if (ph_q) begin
          idx_d = idx_q + 5'd1;
          t_load = state_q == S_ADV || idx_d < len_q;
          t_val = (state_q == S_ADV) ? TW'(OFF_TICKS) : TW'(TIMEOUT_TICKS);
          state_d = (state_q == S_ADV) ? S_GAP : (idx_d < len_q) ? S_WAIT_IN : S_DONE;
        end
      end
      S_GAP: begin
        t_en = 1'b1;
        if (t_done && idx_q < len_q) begin
          state_d = S_SHOW;
          colour_d = colour_now;
          t_load = 1'b1;
          t_val = TW'(ON_TICKS);
        end else if (t_done) begin
          state_d = S_REWIND_IN;
          idx_d = '0;
        end
      end
      S_SETTLE_IN: begin
        state_d = S_WAIT_IN;
        t_load = 1'b1;
        t_val = TW'(TIMEOUT_TICKS);
      end
      S_WAIT_IN: begin
        t_en = 1'b1;
        led = good ? btn : '0;
        fail = bad;
        state_d = good ? S_ADV_IN : bad ? S_IDLE : S_WAIT_IN;
      end
      S_DONE: begin
        pass = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      len_q <= '0;
      colour_q <= '0;
      ph_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      colour_q <= colour_d;
      ph_q <= ph_d;
    end
  end
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: scheduled stimulus with a per-cycle scoreboard built from round-level rules.
module tb_simon_sequencer;
  localparam int ON = 4, OFF = 2, TMO = 20;
  typedef struct packed {
    logic start; logic rst; logic [3:0] btn;
    logic [3:0] led; logic busy; logic pass; logic fail; logic step; logic rerun;
  } cyc_t;
  logic clk = 1'b0, reset, start, random, lfsr_step, lfsr_rerun, busy, pass, fail;
  logic [4:0] level;
  logic [2:0] next_random;
  logic [3:0] btn, led;
  logic [15:0] seed = 16'h0001, lfsr;
  logic mon_en = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  cyc_t sched[$], sb[$];
  always #5 clk = ~clk;
  simon_sequencer #(.ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .level(level), .random(random),
    .next_random(next_random), .btn(btn), .lfsr_step(lfsr_step), .lfsr_rerun(lfsr_rerun),
    .led(led), .busy(busy), .pass(pass), .fail(fail)
  );
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
  function automatic logic [1:0] col_at(input logic [15:0] s, input int j);
    logic [15:0] v = s;
    for (int k = 0; k < 2 * j; k++) v = nxt(v);
    return v[1:0];
  endfunction
  always_ff @(posedge clk) lfsr <= (reset || lfsr_rerun) ? seed : lfsr_step ? nxt(lfsr) : lfsr;
  assign random = lfsr[0];
  assign next_random = lfsr[3:1];
  task automatic chk(input logic cond, input string msg);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask
  task automatic add(input logic st, input logic rs, input logic [3:0] b, input logic [3:0] l,
                     input logic bz, input logic ps, input logic fl, input logic sp, input logic rr);
    cyc_t e;
    e = '{start: st, rst: rs, btn: b, led: l, busy: bz, pass: ps, fail: fl, step: sp, rerun: rr};
    sched.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic build_round(input logic [4:0] lvl, input int wrong_at, input logic [3:0] wrong_btn,
                             input int tmo_at, input int rst_at, input bit busy_start, input int dly);
    int n = (lvl == 0) ? 1 : int'(lvl);
    int d;
    logic [3:0] ld;
    level = lvl;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int j = 0; j < n; j++) begin
      ld = 4'b0001 << col_at(seed, j);
      for (int t = 0; t < ON; t++) begin
        if (j == 0 && t == rst_at) begin
          add(0, 1, 0, ld, 1, 0, 0, 0, 0);
          idle(2);
          return;
        end
        add(0, 0, 0, ld, 1, 0, 0, 0, 0);
      end
      repeat (2) add(0, 0, 0, 0, 1, 0, 0, 1, 0);
      for (int t = 0; t < OFF; t++) add(busy_start && j == 0 && t == 0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int j = 0; j < n; j++) begin
      ld = 4'b0001 << col_at(seed, j);
      if (j == tmo_at) begin
        repeat (TMO - 1) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0);
        idle(2);
        return;
      end
      d = (dly >= 0) ? dly : int'($urandom_range(0, 4));
      repeat (d) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
      if (j == wrong_at) begin
        add(0, 0, wrong_btn, 0, 1, 0, 1, 0, 0);
        idle(2);
        return;
      end
      add(0, 0, ld, ld, 1, 0, 0, 0, 0);
      repeat (2) add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    end
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    idle(2);
  endtask
  task automatic run();
    cyc_t e;
    mon_en = 1'b1;
    while (sched.size() > 0) begin
      e = sched.pop_front();
      @(posedge clk);
      #1;
      start = e.start;
      reset = e.rst;
      btn = e.btn;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (mon_en) begin
    cyc_t e;
    logic [8:0] ex, ob;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    ex = {e.led, e.busy, e.pass, e.fail, e.step, e.rerun};
    ob = {led, busy, pass, fail, lfsr_step, lfsr_rerun};
    checks++;
    cyc++;
    if (ob !== ex) begin
      errors++;
      $display("FAIL cyc %0d outputs{led,busy,pass,fail,step,rerun} got %b exp %b", cyc, ob, ex);
    end
  end
  initial begin
    int n, mode, wa;
    logic [3:0] ok, w;
    reset = 1'b1;
    start = 1'b0;
    btn = '0;
    level = '0;
    repeat (3) @(posedge clk);
    #1;
    chk({led, busy, pass, fail, lfsr_step, lfsr_rerun} === 9'd0, "reset state outputs not zero");
    idle(3);
    build_round(5'd2, -1, 0, -1, -1, 0, -1);
    run();
    build_round(5'd2, 0, 4'b0100, -1, -1, 0, -1);
    run();
    build_round(5'd1, -1, 0, 0, -1, 0, -1);
    run();
    chk({busy, fail, pass, lfsr_step} === 4'b0000, "not idle after expired wait");
    build_round(5'd1, 0, 4'b0011, -1, -1, 0, 0);
    run();
    build_round(5'd2, -1, 0, -1, 1, 0, -1);
    run();
    build_round(5'd3, -1, 0, -1, -1, 1, -1);
    run();
    build_round(5'd0, -1, 0, -1, -1, 0, -1);
    run();
    build_round(5'd1, -1, 0, -1, -1, 0, TMO - 1);
    run();
    for (int r = 0; r < 10; r++) begin
      seed = 16'($urandom_range(1, 65535));
      level = 5'($urandom_range(0, 6));
      n = (level == 0) ? 1 : int'(level);
      mode = int'($urandom_range(0, 3));
      wa = int'($urandom_range(0, n - 1));
      ok = 4'b0001 << col_at(seed, wa);
      w = ok ^ 4'($urandom_range(1, 15));
      if (w == 4'b0000) w = 4'b1111;
      build_round(level, mode == 0 ? wa : -1, w, mode == 1 ? wa : -1, -1, mode == 2, -1);
      run();
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
